instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage. Generates program-counter addresses for the synchronous program ROM.
//  Captures returned 16-bit words and presents them downstream with their PC on a valid/ready handshake.
//  Supports jump redirect and halt. Sits between the ROM (upstream) and the decode stage (downstream).
// PARAMETERS
//  ADDR_WIDTH  11  ROM address / PC width
//  DATA_WIDTH  16  instruction word width
//  RESET_PC    0   PC loaded on reset
// PORTS
//  clk          in   1           system clock, all logic on rising edge
//  rst          in   1           synchronous reset, active-high
//  rom_addr     out  ADDR_WIDTH  address to ROM (= pc register, no combinational path from inputs)
//  rom_data     in   DATA_WIDTH  ROM word; word for address presented in cycle N is valid in cycle N+1
//  instr        out  DATA_WIDTH  instruction at FIFO head
//  instr_pc     out  ADDR_WIDTH  address that instr was fetched from
//  instr_valid  out  1           instr/instr_pc valid
//  instr_ready  in   1           downstream accepts; transfer when valid && ready
//  jump_en      in   1           redirect fetch this cycle
//  jump_addr    in   ADDR_WIDTH  redirect target
//  halt         in   1           level: stop issuing new fetches
//  halted       out  1           high when no fetch issued and none in flight
// BEHAVIOUR
//  State: pc, inflight flag + inflight_pc, 2-entry output FIFO (count 0..2), FSM {RUN, DRAIN, HALTED}.
//  Reset (rst high at an edge): pc=RESET_PC, inflight=0, count=0, FSM=RUN.
//   Outputs after reset: instr_valid=0, instr=0, instr_pc=0, halted=0. Reset overrides all other inputs.
//  pop = instr_valid && instr_ready. instr_valid = (count != 0).
//  issue = (FSM==RUN) && !halt && !jump_en && ((count+inflight) < 2 || pop).
//  On issue: inflight<=1, inflight_pc<=pc, pc<=pc+1 (wraps 2^ADDR_WIDTH-1 -> 0).
//   Otherwise inflight<=0 and pc holds.
//  Capture: when inflight=1 and no jump_en, {rom_data, inflight_pc} pushed to FIFO tail.
//  Push and pop in the same cycle are legal; count never exceeds 2 and never loses or duplicates a word.
//  instr/instr_pc stay stable while instr_valid && !instr_ready.
//  Latency: from the first cycle rst is low (cycle 0), rom_addr=RESET_PC in cycle 0,
//   rom_data valid in cycle 1, instr_valid=1 in cycle 2.
//  Throughput: one instruction per cycle sustained while instr_ready=1.
//  Jump (jump_en=1 in cycle J): pc<=jump_addr, FIFO flushed (count<=0), inflight<=0.
//   The rom_data arriving in J+1 is discarded; nothing is issued in J.
//   jump_en overrides pop (a popped word is still consumed) and capture.
//   Target appears: rom_addr=jump_addr in J+1, instr_valid with instr_pc=jump_addr in J+3.
//  FSM:
//   RUN -> DRAIN    on halt=1 when inflight=1 or an issue would occur
//   RUN -> HALTED   on halt=1 when inflight=0
//   DRAIN -> HALTED when inflight=0
//   HALTED -> RUN   when halt=0
//   halted=1 only in HALTED.
//   FIFO words still drain downstream while in DRAIN/HALTED.
//  Jump while DRAIN/HALTED: pc, flush and inflight updated as above; FSM unchanged.
//   Fetch resumes at jump_addr when halt is released.
//  Simultaneous halt and jump: both take effect.
//  halt=0 in DRAIN: completes to HALTED, then RUN next cycle (no lost or duplicate fetch).
// TESTING
//  1 ROM word i = i+0x7100; rst 2 cycles, ready=1
//    -> instr_valid rises cycle 2; instr_pc 0,1,2,... consecutive, no gaps.
//  2 Streaming, ready=0 for 5 cycles
//    -> instr/instr_pc frozen; rom_addr advances at most 2 past head; on ready=1 sequence resumes, no loss or duplicate.
//  3 jump_en with jump_addr=0x100 mid-stream
//    -> no old-path word accepted after J; instr_pc=0x100 valid in J+3, then 0x101.
//  4 jump_addr=0x7FF
//    -> instr_pc 0x7FF then 0x000 (wrap), data matches ROM.
//  5 halt=1 mid-stream
//    -> halted=1 within 2 cycles, rom_addr constant, buffered words delivered; halt=0 -> next instr_pc continues sequence.
//  6 rst asserted while instr_valid=1, ready=0
//    -> instr_valid=0 next cycle; restart from RESET_PC with cycle-2 latency.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM address/data, downstream valid/ready handshake,
// jump redirect and halt control.
interface instr_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  jump_en;
    logic [ADDR_WIDTH-1:0] jump_addr;
    logic                  halt;
    logic                  halted;

    modport master (
        output rom_addr, instr, instr_pc, instr_valid, halted,
        input  rom_data, instr_ready, jump_en, jump_addr, halt
    );

    modport slave (
        input  rom_addr, instr, instr_pc, instr_valid, halted,
        output rom_data, instr_ready, jump_en, jump_addr, halt
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives PC to a synchronous ROM, buffers returned
// words in a 2-entry FIFO and hands them downstream on valid/ready.
module instr_fetch #(
    parameter int unsigned           ADDR_WIDTH = 11,
    parameter int unsigned           DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [ADDR_WIDTH-1:0] pc0_q, pc0_d, pc1_q, pc1_d;

    logic       pop;
    logic       room;
    logic       issue;
    logic       capture;
    logic [2:0] occupancy;

    // Room exists if buffered plus in-flight words leave a free slot, or a
    // pop this cycle frees one by the time the new word returns.
    always_comb begin
        pop       = (count_q != 2'd0) && bus.instr_ready;
        occupancy = {1'b0, count_q} + {2'b00, inflight_q};
        room      = (occupancy < 3'd2) || pop;
        issue     = (state_q == RUN) && !bus.halt && !bus.jump_en && room;
        capture   = inflight_q && !bus.jump_en;
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (bus.jump_en) begin
            pc_d = bus.jump_addr;
        end else if (issue) begin
            pc_d          = pc_q + 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_comb begin
        logic [1:0] cnt;
        cnt     = count_q;
        data0_d = data0_q;
        data1_d = data1_q;
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
        count_d = count_q;
        if (bus.jump_en) begin
            count_d = '0;
        end else begin
            if (pop) begin
                data0_d = data1_q;
                pc0_d   = pc1_q;
                cnt     = cnt - 2'd1;
            end
            if (capture) begin
                if (cnt == 2'd0) begin
                    data0_d = bus.rom_data;
                    pc0_d   = inflight_pc_q;
                end else begin
                    data1_d = bus.rom_data;
                    pc1_d   = inflight_pc_q;
                end
                cnt = cnt + 2'd1;
            end
            count_d = cnt;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (bus.halt) begin
                    state_d = (inflight_q || (!bus.jump_en && room)) ? DRAIN : HALTED;
                end
            end
            DRAIN: begin
                if (!inflight_q) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (!bus.halt) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            data0_q       <= '0;
            data1_q       <= '0;
            pc0_q         <= '0;
            pc1_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
            pc0_q         <= pc0_d;
            pc1_q         <= pc1_d;
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.instr       = data0_q;
    assign bus.instr_pc    = pc0_q;
    assign bus.instr_valid = (count_q != 2'd0);
    assign bus.halted      = (state_q == HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a ROM model returns addr+0x7100 and a
// queue of expected PCs is checked against every accepted instruction.
module tb_instr_fetch;

    logic clk;
    logic rst;

    instr_fetch_if #(.ADDR_WIDTH(11), .DATA_WIDTH(16)) bus ();

    instr_fetch #(
        .ADDR_WIDTH (11),
        .DATA_WIDTH (16),
        .RESET_PC   (11'h000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        bus.rom_data <= 16'h7100 + {5'b0, bus.rom_addr};
    end

    int unsigned     vectors;
    int unsigned     miscompares;
    int unsigned     pops;
    int unsigned     p0;
    logic [10:0]     exp_q[$];
    logic [10:0]     h_pc;
    logic [10:0]     h_addr;
    logic [15:0]     h_instr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [10:0] start, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back(start + 11'(i));
        end
    endtask

    // Score any transfer happening this cycle, then advance one clock.
    task automatic tick();
        logic [10:0] e;
        if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
            pops++;
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", 32'(bus.instr_pc), 32'(e));
                chk("sb_data", 32'(bus.instr), 32'(16'h7100 + {5'b0, e}));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        pops            = 0;
        rst             = 1'b1;
        bus.instr_ready = 1'b1;
        bus.jump_en     = 1'b0;
        bus.jump_addr   = '0;
        bus.halt        = 1'b0;

        // 1: reset values and start-up latency
        tick();
        tick();
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", 32'(bus.instr), 32'd0);
        chk("rst_pc", 32'(bus.instr_pc), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        push_seq(11'h000, 200);
        chk("c0_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("c0_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("c1_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("c2_valid", 32'(bus.instr_valid), 32'd1);
        chk("c2_pc", 32'(bus.instr_pc), 32'd0);
        p0 = pops;
        repeat (10) tick();
        chk("throughput", pops - p0, 32'd10);
        chk("run_halted", 32'(bus.halted), 32'd0);

        // 2: downstream stall
        bus.instr_ready = 1'b0;
        h_pc    = bus.instr_pc;
        h_instr = bus.instr;
        repeat (5) begin
            tick();
            chk("stall_pc", 32'(bus.instr_pc), 32'(h_pc));
            chk("stall_instr", 32'(bus.instr), 32'(h_instr));
            chk("stall_ahead", 32'(11'(bus.rom_addr - bus.instr_pc) <= 11'd2), 32'd1);
        end
        bus.instr_ready = 1'b1;
        p0 = pops;
        repeat (6) tick();
        chk("resume_rate", pops - p0, 32'd6);

        // 3: jump mid-stream
        bus.jump_addr = 11'h100;
        bus.jump_en   = 1'b1;
        tick();
        bus.jump_en = 1'b0;
        exp_q.delete();
        push_seq(11'h100, 100);
        chk("j1_rom_addr", 32'(bus.rom_addr), 32'h100);
        chk("j1_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("j2_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("j3_valid", 32'(bus.instr_valid), 32'd1);
        chk("j3_pc", 32'(bus.instr_pc), 32'h100);
        tick();
        chk("j4_pc", 32'(bus.instr_pc), 32'h101);
        repeat (3) tick();

        // 4: jump to the top address, PC wraps
        bus.jump_addr = 11'h7FF;
        bus.jump_en   = 1'b1;
        tick();
        bus.jump_en = 1'b0;
        exp_q.delete();
        push_seq(11'h7FF, 100);
        tick();
        tick();
        chk("w3_pc", 32'(bus.instr_pc), 32'h7FF);
        chk("w3_instr", 32'(bus.instr), 32'h78FF);
        tick();
        chk("w4_pc", 32'(bus.instr_pc), 32'h000);
        tick();
        chk("w5_pc", 32'(bus.instr_pc), 32'h001);
        chk("w5_instr", 32'(bus.instr), 32'h7101);
        repeat (3) tick();

        // 5: halt mid-stream, drain, resume
        bus.halt = 1'b1;
        h_addr   = bus.rom_addr;
        tick();
        tick();
        chk("halt_halted", 32'(bus.halted), 32'd1);
        chk("halt_rom_addr", 32'(bus.rom_addr), 32'(h_addr));
        repeat (4) tick();
        chk("halt_rom_hold", 32'(bus.rom_addr), 32'(h_addr));
        chk("halt_drained", 32'(bus.instr_valid), 32'd0);
        chk("halt_still", 32'(bus.halted), 32'd1);
        bus.halt = 1'b0;
        p0 = pops;
        repeat (6) tick();
        chk("unhalt_flow", 32'(pops - p0 >= 1), 32'd1);
        chk("unhalt_halted", 32'(bus.halted), 32'd0);

        // 6: reset while holding a valid word
        bus.instr_ready = 1'b0;
        repeat (3) tick();
        chk("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("rr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rr_instr", 32'(bus.instr), 32'd0);
        chk("rr_pc", 32'(bus.instr_pc), 32'd0);
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        exp_q.delete();
        push_seq(11'h000, 50);
        chk("rr_c0_rom_addr", 32'(bus.rom_addr), 32'd0);
        tick();
        chk("rr_c1_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("rr_c2_valid", 32'(bus.instr_valid), 32'd1);
        chk("rr_c2_pc", 32'(bus.instr_pc), 32'd0);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
